// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the 16-bit CPU. Holds the PC, issues single-cycle word read
//   requests to instruction memory, captures each returned word in an
//   instruction register and offers it to decode through a valid/ready
//   handshake. Supports branch/jump redirect and a HALT opcode that stops
//   fetching until the next redirect or reset.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   imem_req/imem_addr   one-cycle read request and its word address (= PC)
//   imem_rvalid/rdata    read response, at least one cycle after the request
//   instr_valid/ready    handshake towards decode
//   instr, instr_pc      instruction register and the address it came from
//   opcode/rs/rt/imm5    combinational fields of instr (instr[5] unused)
//   redirect_valid/pc    branch/jump taken and its target
//   halted               HALT instruction delivered, fetch stopped
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OP  = 4'hF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [3:0]        opcode,
   output logic [2:0]        rs,
   output logic [2:0]        rt,
   output logic [4:0]        imm5,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN,
      S_HALT
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_req;
   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_valid;
   logic              r_halted;
   logic [3:0]        w_opcode;

   assign w_opcode = r_instr[15:12];

   // r_req is registered alongside the state so it is high exactly for the
   // cycles spent in S_REQ: every branch that enters S_REQ also sets it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_PC;
         r_req      <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_req <= 1'b0;
         // A redirect always wins over the sequential increment below.
         if (redirect_valid) begin
            r_pc <= redirect_pc;
         end
         case (r_state)
            S_BOOT: begin
               r_state <= S_REQ;
               r_req   <= 1'b1;
            end
            S_REQ: begin
               // The request has already gone out; on a redirect its
               // response must be thrown away.
               r_state <= redirect_valid ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (redirect_valid) begin
                     r_state <= S_REQ;
                     r_req   <= 1'b1;
                  end else begin
                     r_instr    <= imem_rdata;
                     r_instr_pc <= r_pc;
                     r_pc       <= r_pc + ADDR_W'(1);
                     r_valid    <= 1'b1;
                     r_state    <= S_HOLD;
                  end
               end else if (redirect_valid) begin
                  r_state <= S_DRAIN;
               end
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  // Completes the transfer if ready, otherwise squashes it.
                  r_valid <= 1'b0;
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
               end else if (instr_ready) begin
                  r_valid <= 1'b0;
                  if (w_opcode == HALT_OP) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state <= S_REQ;
                     r_req   <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               // A redirect here only retargets the PC; the single outstanding
               // response is still the one being discarded.
               if (imem_rvalid) begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
               end
            end
            S_HALT: begin
               if (redirect_valid) begin
                  r_halted <= 1'b0;
                  r_state  <= S_REQ;
                  r_req    <= 1'b1;
               end
            end
            default: begin
               r_state <= S_BOOT;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign halted      = r_halted;

   assign opcode = r_instr[15:12];
   assign rs     = r_instr[11:9];
   assign rt     = r_instr[8:6];
   assign imm5   = r_instr[4:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Bench for instr_fetch_unit: directed scenarios with literal expectations,
//   then randomized traffic, all compared each cycle against a transaction-
//   level model of the fetch stage kept in this file.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic [3:0]  opcode;
   logic [2:0]  rs;
   logic [2:0]  rt;
   logic [4:0]  imm5;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halted;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .RESET_PC(16'h0000),
      .HALT_OP (4'hF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .opcode        (opcode),
      .rs            (rs),
      .rt            (rt),
      .imm5          (imm5),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (transaction level) ----------------
   logic [15:0] m_pc, m_instr, m_ipc;
   bit          m_valid, m_halted, m_boot, m_req, m_out, m_disc;

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
      m_valid = 0; m_halted = 0; m_boot = 1; m_req = 0; m_out = 0; m_disc = 0;
   endtask

   // Advance the model over one clock edge using the inputs the DUT saw.
   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else if (m_boot) begin
         m_boot = 0; m_req = 1;
         if (redirect_valid) m_pc = redirect_pc;
      end else if (m_req) begin
         m_req = 0; m_out = 1; m_disc = redirect_valid;
         if (redirect_valid) m_pc = redirect_pc;
      end else if (m_out) begin
         if (imem_rvalid) begin
            m_out = 0;
            if (m_disc || redirect_valid) begin
               m_req = 1;
               if (redirect_valid) m_pc = redirect_pc;
            end else begin
               m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 16'h0001; m_valid = 1;
            end
         end else if (redirect_valid) begin
            m_disc = 1; m_pc = redirect_pc;
         end
      end else if (m_valid) begin
         if (redirect_valid) begin
            m_valid = 0; m_pc = redirect_pc; m_req = 1;
         end else if (instr_ready) begin
            m_valid = 0;
            if (m_instr[15:12] == 4'hF) m_halted = 1;
            else m_req = 1;
         end
      end else if (m_halted) begin
         if (redirect_valid) begin
            m_halted = 0; m_pc = redirect_pc; m_req = 1;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sync_cmp();
      @(negedge clk);
      chk("imem_req",    16'(imem_req),    16'(m_req));
      chk("imem_addr",   imem_addr,        m_pc);
      chk("instr_valid", 16'(instr_valid), 16'(m_valid));
      chk("instr",       instr,            m_instr);
      chk("instr_pc",    instr_pc,         m_ipc);
      chk("opcode",      16'(opcode),      16'(m_instr[15:12]));
      chk("rs",          16'(rs),          16'(m_instr[11:9]));
      chk("rt",          16'(rt),          16'(m_instr[8:6]));
      chk("imm5",        16'(imm5),        16'(m_instr[4:0]));
      chk("halted",      16'(halted),      16'(m_halted));
   endtask

   // ---------------- instruction memory + input driver ----------------
   bit          mem_busy;
   int          mem_cnt;
   logic [15:0] mem_data;

   task automatic drive_step(input bit rv, input logic [15:0] rpc, input bit rdy,
                             input int lat, input logic [15:0] data, input bit spur);
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
      if (!rst_n) begin
         mem_busy = 0;
         if (spur) imem_rvalid = 1'b1;
      end else if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_data; mem_busy = 0;
         end
      end else if (spur) begin
         imem_rvalid = 1'b1;
      end
      if (rst_n && imem_req) begin
         mem_busy = 1; mem_cnt = lat; mem_data = data;
      end
      redirect_valid = rv;
      redirect_pc    = rpc;
      instr_ready    = rdy;
      @(posedge clk);
      model_step();
   endtask

   // Step idle cycles until a request appears (bounded), then pin its address.
   task automatic wait_req(input logic [15:0] exp_addr, input string nm);
      int n = 0;
      while (!imem_req && n < 8) begin
         chk({nm, "_valid_low"}, 16'(instr_valid), 16'h0000);
         drive_step(0, 16'h0000, 1, 1, 16'($urandom), 0);
         sync_cmp();
         n++;
      end
      chk({nm, "_req"},  16'(imem_req), 16'h0001);
      chk({nm, "_addr"}, imem_addr,     exp_addr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      mem_busy = 0; mem_cnt = 0; mem_data = '0;
      model_reset();
      #2 rst_n = 1'b0;

      // Reset values
      sync_cmp();
      chk("rst_req",    16'(imem_req),    16'h0000);
      chk("rst_addr",   imem_addr,        16'h0000);
      chk("rst_instr",  instr,            16'h0000);
      chk("rst_ipc",    instr_pc,         16'h0000);
      chk("rst_valid",  16'(instr_valid), 16'h0000);
      chk("rst_halted", 16'(halted),      16'h0000);

      // 1: first fetch returns 0x1234 one cycle after the request
      rst_n = 1'b1;
      drive_step(0, 16'h0, 1, 1, 16'h1234, 0);     // BOOT
      sync_cmp();
      chk("t1_req",  16'(imem_req), 16'h0001);
      chk("t1_addr", imem_addr,     16'h0000);
      drive_step(0, 16'h0, 1, 1, 16'h1234, 0);     // REQ
      sync_cmp();
      chk("t1_wait_valid", 16'(instr_valid), 16'h0000);
      drive_step(0, 16'h0, 1, 1, 16'h0, 0);        // WAIT, response arrives
      sync_cmp();
      chk("t1_instr", instr,            16'h1234);
      chk("t1_ipc",   instr_pc,         16'h0000);
      chk("t1_imm5",  16'(imm5),        16'h0014);
      chk("t1_valid", 16'(instr_valid), 16'h0001);
      drive_step(0, 16'h0, 1, 1, 16'h0, 0);        // HOLD, accepted
      sync_cmp();
      chk("t1_next_req",  16'(imem_req), 16'h0001);
      chk("t1_next_addr", imem_addr,     16'h0001);

      // 2: decode stalls for 5 cycles
      drive_step(0, 16'h0, 0, 1, 16'h2345, 0);
      sync_cmp();
      drive_step(0, 16'h0, 0, 1, 16'h0, 0);
      sync_cmp();
      for (int i = 0; i < 5; i++) begin
         chk("t2_valid", 16'(instr_valid), 16'h0001);
         chk("t2_instr", instr,            16'h2345);
         chk("t2_noreq", 16'(imem_req),    16'h0000);
         drive_step(0, 16'h0, (i == 4), 1, 16'h0, 0);
         sync_cmp();
      end
      chk("t2_req",  16'(imem_req), 16'h0001);
      chk("t2_addr", imem_addr,     16'h0002);

      // 3: redirect during WAIT, response two cycles later is dropped
      drive_step(0, 16'h0, 1, 3, 16'h5555, 0);
      sync_cmp();
      drive_step(1, 16'h0040, 1, 1, 16'h0, 0);
      sync_cmp();
      wait_req(16'h0040, "t3");

      // 4: redirect squashes an unaccepted instruction
      drive_step(0, 16'h0, 1, 1, 16'h3000, 0);
      sync_cmp();
      drive_step(0, 16'h0, 0, 1, 16'h0, 0);
      sync_cmp();
      chk("t4_hold_valid", 16'(instr_valid), 16'h0001);
      drive_step(1, 16'h0008, 0, 1, 16'h0, 0);
      sync_cmp();
      chk("t4_valid", 16'(instr_valid), 16'h0000);
      chk("t4_req",   16'(imem_req),    16'h0001);
      chk("t4_addr",  imem_addr,        16'h0008);

      // 5: HALT fetched from FFFF, PC wraps, redirect resumes
      drive_step(1, 16'hFFFF, 1, 1, 16'h1111, 0);
      sync_cmp();
      wait_req(16'hFFFF, "t5");
      drive_step(0, 16'h0, 0, 1, 16'hF000, 0);
      sync_cmp();
      drive_step(0, 16'h0, 0, 1, 16'h0, 0);
      sync_cmp();
      chk("t5_instr",  instr,        16'hF000);
      chk("t5_ipc",    instr_pc,     16'hFFFF);
      chk("t5_opcode", 16'(opcode),  16'h000F);
      drive_step(0, 16'h0, 1, 1, 16'h0, 0);
      sync_cmp();
      chk("t5_halted", 16'(halted),      16'h0001);
      chk("t5_valid",  16'(instr_valid), 16'h0000);
      chk("t5_wrap",   imem_addr,        16'h0000);
      for (int i = 0; i < 4; i++) begin
         drive_step(0, 16'h0, 1, 1, 16'h0, 1);
         sync_cmp();
         chk("t5_noreq", 16'(imem_req), 16'h0000);
      end
      drive_step(1, 16'h0010, 1, 1, 16'h0, 0);
      sync_cmp();
      chk("t5_unhalt", 16'(halted),   16'h0000);
      chk("t5_req",    16'(imem_req), 16'h0001);
      chk("t5_addr",   imem_addr,     16'h0010);

      // 6: reset asserted while waiting, stale response afterwards
      drive_step(0, 16'h0, 1, 2, 16'h7777, 0);
      sync_cmp();
      rst_n = 1'b0;
      #1;
      chk("t6_req",    16'(imem_req),    16'h0000);
      chk("t6_addr",   imem_addr,        16'h0000);
      chk("t6_valid",  16'(instr_valid), 16'h0000);
      chk("t6_instr",  instr,            16'h0000);
      chk("t6_ipc",    instr_pc,         16'h0000);
      chk("t6_halted", 16'(halted),      16'h0000);
      model_reset();
      mem_busy = 0;
      drive_step(0, 16'h0, 1, 1, 16'h0, 1);
      sync_cmp();
      rst_n = 1'b1;
      drive_step(0, 16'h0, 1, 1, 16'h0, 1);        // BOOT with stale rvalid
      sync_cmp();
      chk("t6_boot_req",  16'(imem_req), 16'h0001);
      chk("t6_boot_addr", imem_addr,     16'h0000);
      drive_step(0, 16'h0, 1, 1, 16'h4444, 1);     // REQ with stale rvalid
      sync_cmp();
      drive_step(0, 16'h0, 1, 1, 16'h0, 0);
      sync_cmp();
      chk("t6_instr", instr,    16'h4444);
      chk("t6_ipc",   instr_pc, 16'h0000);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit          rv;
         logic [15:0] rpc;
         rv  = ($urandom % 10) == 0;
         rpc = (($urandom % 4) == 0) ? (16'hFFFE + 16'($urandom % 2)) : 16'($urandom);
         drive_step(rv, rpc, ($urandom % 3) != 0, int'($urandom_range(1, 3)),
                    16'($urandom), ($urandom % 6) == 0);
         sync_cmp();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
